// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode handshake bundle around the instruction queue
interface inst_queue_if;
  logic        FetchValid1, FetchValid2, FetchValid3, FetchValid4;
  logic [31:0] FetchAddr1, FetchAddr2, FetchAddr3, FetchAddr4;
  logic [31:0] FetchDate1, FetchDate2, FetchDate3, FetchDate4;
  logic [31:0] FetchNAdr1, FetchNAdr2, FetchNAdr3, FetchNAdr4;
  logic        FetchPart1, FetchPart2, FetchPart3, FetchPart4;
  logic        FetchReady;
  logic        DecodeStopS;
  logic        DecodeFlashS;
  logic        InInstPort1, InInstPort2, InInstPort3, InInstPort4;
  logic [31:0] InInstAddr1, InInstAddr2, InInstAddr3, InInstAddr4;
  logic [31:0] InInstDate1, InInstDate2, InInstDate3, InInstDate4;
  logic [31:0] InInstNAdr1, InInstNAdr2, InInstNAdr3, InInstNAdr4;
  logic        InInstPart1, InInstPart2, InInstPart3, InInstPart4;
  logic        QueueEmpty;

  modport master (
    output FetchValid1, FetchValid2, FetchValid3, FetchValid4,
    output FetchAddr1, FetchAddr2, FetchAddr3, FetchAddr4,
    output FetchDate1, FetchDate2, FetchDate3, FetchDate4,
    output FetchNAdr1, FetchNAdr2, FetchNAdr3, FetchNAdr4,
    output FetchPart1, FetchPart2, FetchPart3, FetchPart4,
    input  FetchReady,
    output DecodeStopS, DecodeFlashS,
    input  InInstPort1, InInstPort2, InInstPort3, InInstPort4,
    input  InInstAddr1, InInstAddr2, InInstAddr3, InInstAddr4,
    input  InInstDate1, InInstDate2, InInstDate3, InInstDate4,
    input  InInstNAdr1, InInstNAdr2, InInstNAdr3, InInstNAdr4,
    input  InInstPart1, InInstPart2, InInstPart3, InInstPart4,
    input  QueueEmpty
  );

  modport slave (
    input  FetchValid1, FetchValid2, FetchValid3, FetchValid4,
    input  FetchAddr1, FetchAddr2, FetchAddr3, FetchAddr4,
    input  FetchDate1, FetchDate2, FetchDate3, FetchDate4,
    input  FetchNAdr1, FetchNAdr2, FetchNAdr3, FetchNAdr4,
    input  FetchPart1, FetchPart2, FetchPart3, FetchPart4,
    output FetchReady,
    input  DecodeStopS, DecodeFlashS,
    output InInstPort1, InInstPort2, InInstPort3, InInstPort4,
    output InInstAddr1, InInstAddr2, InInstAddr3, InInstAddr4,
    output InInstDate1, InInstDate2, InInstDate3, InInstDate4,
    output InInstNAdr1, InInstNAdr2, InInstNAdr3, InInstNAdr4,
    output InInstPart1, InInstPart2, InInstPart3, InInstPart4,
    output QueueEmpty
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - 4-wide circular instruction buffer between fetch and decode
module inst_queue #(
  parameter int DEPTH = 16
) (
  input logic         Clk,
  input logic         Rest,
  inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] date;
    logic        part;
    logic [31:0] nadr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    out_vld_q, out_vld_d;
  entry_t        out_q [4];
  entry_t        out_d [4];

  logic [3:0]    f_valid;
  entry_t        f_entry [4];
  logic [CW-1:0] free_slots;
  logic          fetch_ready;
  logic [2:0]    npush;
  logic [2:0]    npush_eff;
  logic          push_en;
  logic [2:0]    npop;

  always_comb begin
    f_valid    = {q.FetchValid4, q.FetchValid3, q.FetchValid2, q.FetchValid1};
    f_entry[0] = {q.FetchAddr1, q.FetchDate1, q.FetchPart1, q.FetchNAdr1};
    f_entry[1] = {q.FetchAddr2, q.FetchDate2, q.FetchPart2, q.FetchNAdr2};
    f_entry[2] = {q.FetchAddr3, q.FetchDate3, q.FetchPart3, q.FetchNAdr3};
    f_entry[3] = {q.FetchAddr4, q.FetchDate4, q.FetchPart4, q.FetchNAdr4};
  end

  // Ready depends only on the registered count so fetch never sees a combinational loop.
  assign free_slots  = CW'(DEPTH) - count_q;
  assign fetch_ready = free_slots >= CW'(4);

  always_comb begin
    npush = 3'd0;
    if (f_valid[0])                                         npush = 3'd1;
    if (f_valid[0] && f_valid[1])                           npush = 3'd2;
    if (f_valid[0] && f_valid[1] && f_valid[2])             npush = 3'd3;
    if (f_valid[0] && f_valid[1] && f_valid[2] && f_valid[3]) npush = 3'd4;
  end

  assign push_en   = f_valid[0] && fetch_ready && !q.DecodeFlashS && !Rest;
  assign npush_eff = push_en ? npush : 3'd0;

  always_comb begin
    npop = 3'd0;
    if (!q.DecodeStopS && !q.DecodeFlashS) begin
      npop = (count_q >= CW'(4)) ? 3'd4 : count_q[2:0];
    end
  end

  always_comb begin
    wptr_d    = wptr_q + AW'(npush_eff);
    rptr_d    = rptr_q + AW'(npop);
    count_d   = count_q + CW'(npush_eff) - CW'(npop);
    out_vld_d = out_vld_q;
    for (int k = 0; k < 4; k++) begin
      out_d[k] = out_q[k];
    end
    if (q.DecodeFlashS) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      out_vld_d = '0;
      for (int k = 0; k < 4; k++) begin
        out_d[k] = '0;
      end
    end else if (!q.DecodeStopS) begin
      // Only entries present before this edge are read; same-edge pushes land in free slots.
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < npop) begin
          out_vld_d[k] = 1'b1;
          out_d[k]     = mem_q[rptr_q + AW'(k)];
        end else begin
          out_vld_d[k] = 1'b0;
          out_d[k]     = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_en && (3'(k) < npush)) begin
        mem_q[wptr_q + AW'(k)] <= f_entry[k];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      out_vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= out_d[k];
      end
    end
  end

  assign q.FetchReady = fetch_ready;
  assign q.QueueEmpty = (count_q == '0);

  assign q.InInstPort1 = out_vld_q[0];
  assign q.InInstPort2 = out_vld_q[1];
  assign q.InInstPort3 = out_vld_q[2];
  assign q.InInstPort4 = out_vld_q[3];
  assign q.InInstAddr1 = out_q[0].addr;
  assign q.InInstAddr2 = out_q[1].addr;
  assign q.InInstAddr3 = out_q[2].addr;
  assign q.InInstAddr4 = out_q[3].addr;
  assign q.InInstDate1 = out_q[0].date;
  assign q.InInstDate2 = out_q[1].date;
  assign q.InInstDate3 = out_q[2].date;
  assign q.InInstDate4 = out_q[3].date;
  assign q.InInstNAdr1 = out_q[0].nadr;
  assign q.InInstNAdr2 = out_q[1].nadr;
  assign q.InInstNAdr3 = out_q[2].nadr;
  assign q.InInstNAdr4 = out_q[3].nadr;
  assign q.InInstPart1 = out_q[0].part;
  assign q.InInstPart2 = out_q[1].part;
  assign q.InInstPart3 = out_q[2].part;
  assign q.InInstPart4 = out_q[3].part;
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed and scoreboarded checks of inst_queue
module tb_inst_queue;
  logic Clk = 1'b0;
  logic Rest;
  always #5 Clk = ~Clk;

  inst_queue_if q_if ();
  inst_queue #(.DEPTH(16)) dut (.Clk(Clk), .Rest(Rest), .q(q_if));

  logic [3:0]  f_valid;
  logic [31:0] f_addr [4];
  logic [31:0] f_date [4];
  logic [31:0] f_nadr [4];
  logic [3:0]  f_part;
  logic        stop, flash;

  assign q_if.FetchValid1 = f_valid[0];
  assign q_if.FetchValid2 = f_valid[1];
  assign q_if.FetchValid3 = f_valid[2];
  assign q_if.FetchValid4 = f_valid[3];
  assign q_if.FetchAddr1 = f_addr[0];
  assign q_if.FetchAddr2 = f_addr[1];
  assign q_if.FetchAddr3 = f_addr[2];
  assign q_if.FetchAddr4 = f_addr[3];
  assign q_if.FetchDate1 = f_date[0];
  assign q_if.FetchDate2 = f_date[1];
  assign q_if.FetchDate3 = f_date[2];
  assign q_if.FetchDate4 = f_date[3];
  assign q_if.FetchNAdr1 = f_nadr[0];
  assign q_if.FetchNAdr2 = f_nadr[1];
  assign q_if.FetchNAdr3 = f_nadr[2];
  assign q_if.FetchNAdr4 = f_nadr[3];
  assign q_if.FetchPart1 = f_part[0];
  assign q_if.FetchPart2 = f_part[1];
  assign q_if.FetchPart3 = f_part[2];
  assign q_if.FetchPart4 = f_part[3];
  assign q_if.DecodeStopS  = stop;
  assign q_if.DecodeFlashS = flash;

  logic [3:0]  o_port;
  logic [3:0]  o_part;
  logic [31:0] o_addr [4];
  logic [31:0] o_date [4];
  logic [31:0] o_nadr [4];
  assign o_port = {q_if.InInstPort4, q_if.InInstPort3, q_if.InInstPort2, q_if.InInstPort1};
  assign o_part = {q_if.InInstPart4, q_if.InInstPart3, q_if.InInstPart2, q_if.InInstPart1};
  assign o_addr[0] = q_if.InInstAddr1;
  assign o_addr[1] = q_if.InInstAddr2;
  assign o_addr[2] = q_if.InInstAddr3;
  assign o_addr[3] = q_if.InInstAddr4;
  assign o_date[0] = q_if.InInstDate1;
  assign o_date[1] = q_if.InInstDate2;
  assign o_date[2] = q_if.InInstDate3;
  assign o_date[3] = q_if.InInstDate4;
  assign o_nadr[0] = q_if.InInstNAdr1;
  assign o_nadr[1] = q_if.InInstNAdr2;
  assign o_nadr[2] = q_if.InInstNAdr3;
  assign o_nadr[3] = q_if.InInstNAdr4;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] dt(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_fetch(input logic [3:0] mask, input logic [31:0] base);
    f_valid = mask;
    for (int k = 0; k < 4; k++) begin
      f_addr[k] = base + 32'(4 * k);
      f_date[k] = dt(f_addr[k]);
      f_nadr[k] = f_addr[k] + 32'd4;
      f_part[k] = f_addr[k][2];
    end
  endtask

  task automatic clr_fetch;
    f_valid = 4'b0000;
  endtask

  task automatic test_reset;
    Rest = 1'b1; stop = 1'b0; flash = 1'b0;
    set_fetch(4'hF, 32'h5555_0000);
    tick; tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL reset_port got %h want 0", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h0) begin n_fail++; $display("FAIL reset_addr1 got %h want 0", o_addr[0]); end
    n_cmp++; if (o_date[3] !== 32'h0) begin n_fail++; $display("FAIL reset_date4 got %h want 0", o_date[3]); end
    n_cmp++; if (q_if.FetchReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", q_if.FetchReady); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", q_if.QueueEmpty); end
    Rest = 1'b0;
    clr_fetch;
  endtask

  task automatic test_push4;
    set_fetch(4'hF, 32'h1C00_0000);
    tick;
    clr_fetch;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL push4_latency got %h want 0", o_port); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b0) begin n_fail++; $display("FAIL push4_notempty got %b want 0", q_if.QueueEmpty); end
    n_cmp++; if (q_if.FetchReady !== 1'b1) begin n_fail++; $display("FAIL push4_ready got %b want 1", q_if.FetchReady); end
    tick;
    n_cmp++; if (o_port !== 4'hF) begin n_fail++; $display("FAIL push4_port got %h want f", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h1C00_0000) begin n_fail++; $display("FAIL push4_addr1 got %h want 1c000000", o_addr[0]); end
    n_cmp++; if (o_addr[3] !== 32'h1C00_000C) begin n_fail++; $display("FAIL push4_addr4 got %h want 1c00000c", o_addr[3]); end
    n_cmp++; if (o_date[1] !== 32'hB9A5_A5A1) begin n_fail++; $display("FAIL push4_date2 got %h want b9a5a5a1", o_date[1]); end
    n_cmp++; if (o_nadr[3] !== 32'h1C00_0010) begin n_fail++; $display("FAIL push4_nadr4 got %h want 1c000010", o_nadr[3]); end
    n_cmp++; if (o_part !== 4'b1010) begin n_fail++; $display("FAIL push4_part got %b want 1010", o_part); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL push4_empty got %b want 1", q_if.QueueEmpty); end
    tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL push4_drain_port got %h want 0", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h0) begin n_fail++; $display("FAIL push4_drain_addr got %h want 0", o_addr[0]); end
  endtask

  task automatic test_stall;
    set_fetch(4'b0111, 32'h3000_0000);
    tick;
    stop = 1'b1;
    set_fetch(4'b0011, 32'h3000_0100);
    tick;
    clr_fetch;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL stall_hold got %h want 0", o_port); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b0) begin n_fail++; $display("FAIL stall_empty got %b want 0", q_if.QueueEmpty); end
    tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL stall_hold2 got %h want 0", o_port); end
    stop = 1'b0;
    tick;
    n_cmp++; if (o_port !== 4'hF) begin n_fail++; $display("FAIL stall_pop1_port got %h want f", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h3000_0000) begin n_fail++; $display("FAIL stall_pop1_a1 got %h want 30000000", o_addr[0]); end
    n_cmp++; if (o_addr[2] !== 32'h3000_0008) begin n_fail++; $display("FAIL stall_pop1_a3 got %h want 30000008", o_addr[2]); end
    n_cmp++; if (o_addr[3] !== 32'h3000_0100) begin n_fail++; $display("FAIL stall_pop1_a4 got %h want 30000100", o_addr[3]); end
    tick;
    n_cmp++; if (o_port !== 4'b0001) begin n_fail++; $display("FAIL stall_pop2_port got %b want 0001", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h3000_0104) begin n_fail++; $display("FAIL stall_pop2_a1 got %h want 30000104", o_addr[0]); end
    n_cmp++; if (o_addr[1] !== 32'h0) begin n_fail++; $display("FAIL stall_pop2_a2 got %h want 0", o_addr[1]); end
    tick;
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL stall_final_empty got %b want 1", q_if.QueueEmpty); end
  endtask

  task automatic test_full;
    set_fetch(4'hF, 32'h4000_0000);
    tick;
    clr_fetch;
    tick;
    stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (q_if.FetchReady !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d got %b want 1", i, q_if.FetchReady); end
      set_fetch(4'hF, 32'h2000_0000 + 32'(16 * i));
      tick;
    end
    clr_fetch;
    n_cmp++; if (q_if.FetchReady !== 1'b0) begin n_fail++; $display("FAIL full_notready got %b want 0", q_if.FetchReady); end
    set_fetch(4'hF, 32'hDEAD_0000);
    tick;
    clr_fetch;
    n_cmp++; if (q_if.FetchReady !== 1'b0) begin n_fail++; $display("FAIL full_still_notready got %b want 0", q_if.FetchReady); end
    n_cmp++; if (o_port !== 4'hF) begin n_fail++; $display("FAIL full_hold_port got %h want f", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h4000_0000) begin n_fail++; $display("FAIL full_hold_a1 got %h want 40000000", o_addr[0]); end
    stop = 1'b0;
    for (int g = 0; g < 4; g++) begin
      tick;
      n_cmp++; if (o_port !== 4'hF) begin n_fail++; $display("FAIL full_pop%0d_port got %h want f", g, o_port); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (o_addr[k] !== 32'h2000_0000 + 32'(16 * g + 4 * k)) begin
          n_fail++; $display("FAIL full_pop%0d_a%0d got %h want %h", g, k, o_addr[k], 32'h2000_0000 + 32'(16 * g + 4 * k));
        end
      end
      if (g == 0) begin
        n_cmp++; if (q_if.FetchReady !== 1'b1) begin n_fail++; $display("FAIL full_recover got %b want 1", q_if.FetchReady); end
      end
    end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b want 1", q_if.QueueEmpty); end
    tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL full_no_extra got %h want 0", o_port); end
  endtask

  task automatic test_mask;
    set_fetch(4'b1101, 32'h5000_0000);
    tick;
    clr_fetch;
    tick;
    n_cmp++; if (o_port !== 4'b0001) begin n_fail++; $display("FAIL mask_port got %b want 0001", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h5000_0000) begin n_fail++; $display("FAIL mask_a1 got %h want 50000000", o_addr[0]); end
    n_cmp++; if (o_addr[2] !== 32'h0) begin n_fail++; $display("FAIL mask_a3 got %h want 0", o_addr[2]); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL mask_empty got %b want 1", q_if.QueueEmpty); end
  endtask

  task automatic test_flush;
    stop = 1'b1;
    set_fetch(4'hF, 32'h6000_0000);
    tick;
    set_fetch(4'b0111, 32'h6000_0010);
    tick;
    n_cmp++; if (q_if.QueueEmpty !== 1'b0) begin n_fail++; $display("FAIL flush_pre_empty got %b want 0", q_if.QueueEmpty); end
    n_cmp++; if (o_port !== 4'b0001) begin n_fail++; $display("FAIL flush_pre_hold got %b want 0001", o_port); end
    flash = 1'b1;
    set_fetch(4'hF, 32'h7000_0000);
    tick;
    clr_fetch;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL flush_port got %h want 0", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h0) begin n_fail++; $display("FAIL flush_a1 got %h want 0", o_addr[0]); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b want 1", q_if.QueueEmpty); end
    n_cmp++; if (q_if.FetchReady !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", q_if.FetchReady); end
    flash = 1'b0;
    stop  = 1'b0;
    tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL flush_no_ghost got %h want 0", o_port); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL flush_after_empty got %b want 1", q_if.QueueEmpty); end
  endtask

  task automatic test_random;
    logic [31:0] exp_q [$];
    logic [31:0] exp_addr [4];
    logic [3:0]  exp_port;
    logic [31:0] seq;
    logic [3:0]  mask;
    int          mcount, n, npush, npop;
    logic        st, accept;
    mcount   = 0;
    exp_port = 4'h0;
    seq      = 32'h8000_0000;
    for (int k = 0; k < 4; k++) exp_addr[k] = 32'h0;
    for (int c = 0; c < 200; c++) begin
      st = ($urandom % 4) == 0;
      n  = int'($urandom_range(0, 4));
      mask = 4'((1 << n) - 1);
      npush = n;
      if (n == 4 && ($urandom % 6) == 0) begin
        mask = 4'b1011;
        npush = 2;
      end
      accept = mask[0] && ((16 - mcount) >= 4);
      n_cmp++;
      if (q_if.FetchReady !== ((16 - mcount) >= 4)) begin
        n_fail++; $display("FAIL rand_ready c%0d got %b model count %0d", c, q_if.FetchReady, mcount);
      end
      set_fetch(mask, seq);
      stop = st;
      npop = st ? 0 : ((mcount >= 4) ? 4 : mcount);
      tick;
      if (!st) begin
        for (int k = 0; k < 4; k++) begin
          exp_port[k] = (k < npop);
          exp_addr[k] = (k < npop) ? exp_q.pop_front() : 32'h0;
        end
      end
      if (accept) begin
        for (int k = 0; k < npush; k++) exp_q.push_back(seq + 32'(4 * k));
        seq    = seq + 32'(4 * npush);
        mcount = mcount + npush;
      end
      mcount = mcount - npop;
      n_cmp++;
      if (o_port !== exp_port) begin n_fail++; $display("FAIL rand_port c%0d got %b want %b", c, o_port, exp_port); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (o_addr[k] !== exp_addr[k]) begin
          n_fail++; $display("FAIL rand_addr c%0d s%0d got %h want %h", c, k, o_addr[k], exp_addr[k]);
        end
        n_cmp++;
        if (o_date[k] !== (exp_port[k] ? dt(exp_addr[k]) : 32'h0)) begin
          n_fail++; $display("FAIL rand_date c%0d s%0d got %h", c, k, o_date[k]);
        end
      end
      n_cmp++;
      if (q_if.QueueEmpty !== (mcount == 0)) begin
        n_fail++; $display("FAIL rand_empty c%0d got %b model count %0d", c, q_if.QueueEmpty, mcount);
      end
    end
    clr_fetch;
    stop = 1'b0;
    repeat (5) tick;
    set_fetch(4'hF, 32'h9000_0000);
    tick;
    set_fetch(4'hF, 32'h9000_0010);
    tick;
    n_cmp++; if (o_port !== 4'hF) begin n_fail++; $display("FAIL midrst_pre_port got %h want f", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h9000_0000) begin n_fail++; $display("FAIL midrst_pre_a1 got %h want 90000000", o_addr[0]); end
    Rest = 1'b1;
    set_fetch(4'hF, 32'h9000_0020);
    tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL midrst_port got %h want 0", o_port); end
    n_cmp++; if (o_addr[0] !== 32'h0) begin n_fail++; $display("FAIL midrst_a1 got %h want 0", o_addr[0]); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got %b want 1", q_if.QueueEmpty); end
    n_cmp++; if (q_if.FetchReady !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", q_if.FetchReady); end
    Rest = 1'b0;
    clr_fetch;
    tick;
    n_cmp++; if (o_port !== 4'h0) begin n_fail++; $display("FAIL midrst_after_port got %h want 0", o_port); end
    n_cmp++; if (q_if.QueueEmpty !== 1'b1) begin n_fail++; $display("FAIL midrst_after_empty got %b want 1", q_if.QueueEmpty); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    Rest  = 1'b1;
    stop  = 1'b0;
    flash = 1'b0;
    set_fetch(4'h0, 32'h0);
    test_reset;
    test_push4;
    test_stall;
    test_full;
    test_mask;
    test_flush;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, 16, entry count of the circular instruction buffer; power of two, at least 8.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Rest  input  1  reset, synchronous, active-high.
REQ-004 FetchValidN (N=1..4)  input  1 each  fetch slot N carries an instruction; valid slots form a prefix (slot 1 first).
REQ-005 FetchAddrN / FetchDateN / FetchNAdrN (N=1..4)  input  32 each  slot N PC, instruction word, predicted next PC.
REQ-006 FetchPartN (N=1..4)  input  1 each  slot N predicted-taken flag.
REQ-007 FetchReady  output  1  queue can accept a push this cycle.
REQ-008 DecodeStopS  input  1  decode stall; hold outputs, no pop.
REQ-009 DecodeFlashS  input  1  flush; discard all queued and output instructions.
REQ-010 InInstPortN (N=1..4)  output  1 each  decode slot N valid.
REQ-011 InInstAddrN / InInstDateN / InInstNAdrN (N=1..4)  output  32 each  slot N PC, word, next PC.
REQ-012 InInstPartN (N=1..4)  output  1 each  slot N predicted-taken flag.
REQ-013 QueueEmpty  output  1  count equals 0.

Function
REQ-014 Storage: DEPTH entries of {Addr, Date, Part, NAdr}; write pointer, read pointer (log2 DEPTH bits, wrap mod DEPTH), count (log2 DEPTH + 1 bits).
REQ-015 FetchReady = (DEPTH - count) >= 4, combinational from registered count only; not a function of any input.
REQ-016 Push: when FetchValid1 && FetchReady && !DecodeFlashS, npush = number of leading consecutive asserted FetchValidN (1..4); slot k writes entry (wptr+k-1) mod DEPTH; wptr advances by npush. Slots after the first deasserted slot are ignored.
REQ-017 No push when FetchReady is low; fetch data presented then is dropped, and fetch must hold it.
REQ-018 Pop: when !DecodeStopS && !DecodeFlashS, npop = min(count, 4) using count before the edge; entries rptr..rptr+npop-1 load output slots 1..npop; InInstPortN = 1 for N <= npop, 0 otherwise; rptr advances by npop.
REQ-019 Unpopped output slots drive data 0 with InInstPortN = 0.
REQ-020 Same-edge push and pop: count_next = count + npush - npop; pushed entries are not eligible for pop until the following edge (min latency: push at edge t, visible on outputs after edge t+1).
REQ-021 DecodeStopS=1 (no flush): all InInstPort/InInst* outputs hold their values; rptr holds; pushes continue per REQ-016.
REQ-022 DecodeFlashS=1: wptr, rptr, count cleared to 0; all InInstPortN cleared; any same-cycle push is dropped; priority Flash > Stop > normal.
REQ-023 Output order: slot 1 always holds the oldest popped instruction; program order is preserved across wrap-around.
REQ-024 QueueEmpty = (count == 0), combinational from registered count.
REQ-025 Count never exceeds DEPTH and never underflows.

Reset
REQ-026 Rest=1 at an edge: wptr=rptr=count=0; all InInstPortN=0; all InInst* data outputs 0; FetchReady=1 and QueueEmpty=1 after that edge.
REQ-027 Rest has priority over DecodeFlashS, DecodeStopS and push; asserting it mid-operation discards all contents exactly as in REQ-026.
REQ-028 Storage array contents need not reset; only pointers, count and output registers reset.

Verification
REQ-029 Reset then push 4 (Addr 0x1C000000..0x1C00000C): after the next edge InInstPort1..4=1, InInstAddr1=0x1C000000, InInstAddr4=0x1C00000C, and QueueEmpty=1.
REQ-030 Push 3, then 2 while DecodeStopS=1: outputs hold and count=5; release the stall; the first pop gives 4 entries in order and the next gives 1 (InInstPort1=1, Port2..4=0).
REQ-031 Hold DecodeStopS, push until FetchReady=0 (count=16-3=13 or higher triggers at count>12); check no extra push is accepted, FetchReady recovers after a pop, and no entry is lost or duplicated.
REQ-032 Push a FetchValid mask of 1,0,1,1: only slot 1 is enqueued (npush=1).
REQ-033 Assert DecodeFlashS together with a push while count=7: after the edge count=0, QueueEmpty=1, all InInstPortN=0, and the pushed data never appears.
REQ-034 Run 100+ cycles of random push/stall with pointer wrap-around: the output stream matches a scoreboard in order, and asserting Rest mid-stream clears the outputs on the next edge.
